// File: rtl/wb_ledport_arb.sv
// Round-robin sequencer that shares one LED port slave among several
// Wishbone requesters. Each transaction produces a single-cycle cs_o pulse;
// posted writes are acknowledged locally, reads and ERC writes wait for the
// port ack with a timeout that returns an error response.
//
// Handshake: a requester raises cs_i[k] with a stable req_i[k] and holds it
// until it sees ack or err on resp_o[k], which is valid for exactly one cycle;
// towards the port, cs_o is a one-cycle strobe qualified by req_o, and only
// resp_i.ack in WAIT is honoured.

package wishbone_pkg;
    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] ERC     = 3'b111;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] ERR  = 2'b01;

    typedef struct packed {
        logic [2:0]  cti;
        logic        we;
        logic [7:0]  sel;
        logic [31:0] adr;
        logic [7:0]  tid;
        logic [63:0] dat;
    } wb_cmd_request64_t;

    typedef struct packed {
        logic        ack;
        logic        rty;
        logic [1:0]  err;
        logic [2:0]  pri;
        logic [7:0]  tid;
        logic [63:0] dat;
    } wb_cmd_response64_t;
endpackage

module wb_ledport_arb
    import wishbone_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    cs_i,
    input  wb_cmd_request64_t  req_i [NREQ],
    output wb_cmd_response64_t resp_o [NREQ],
    output logic [NREQ-1:0]    grant_o,
    output logic               cs_o,
    output wb_cmd_request64_t  req_o,
    input  wb_cmd_response64_t resp_i,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    localparam int         IW   = $clog2(NREQ);
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      ptr, ptr_n;       // last granted requester, also the current owner
    logic [IW-1:0]      cand;
    logic               found;
    logic [NREQ-1:0]    grant_n;
    wb_cmd_request64_t  req_n;
    wb_cmd_response64_t resp_n [NREQ];
    logic [7:0]         timer, timer_n;
    logic               ack_exp;

    assign cs_o      = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Next-state, arbitration and response formation
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant_o;
        req_n   = req_o;
        timer_n = timer;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            resp_n[i] = '0;
        end
        ack_exp = !req_o.we || (req_o.cti == ERC);

        case (state)
            IDLE: begin
                // Scan starts just past the last owner so every waiter is
                // served within NREQ-1 other transactions.
                for (int i = 1; i <= NREQ; i++) begin
                    cand = IW'((int'(ptr) + i) % NREQ);
                    if (!found && cs_i[cand]) begin
                        found = 1'b1;
                        ptr_n = cand;
                    end
                end
                if (found) begin
                    req_n   = req_i[ptr_n];
                    grant_n = {{(NREQ-1){1'b0}}, 1'b1} << ptr_n;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_exp) begin
                    timer_n = '0;
                    state_n = WAIT;
                end else begin
                    // The port never acks posted writes, so answer locally.
                    resp_n[ptr].ack = 1'b1;
                    resp_n[ptr].err = OKAY;
                    resp_n[ptr].pri = 3'd7;
                    resp_n[ptr].tid = req_o.tid;
                    state_n = RESP;
                end
            end
            WAIT: begin
                if (resp_i.ack) begin
                    resp_n[ptr] = resp_i;
                    state_n     = RESP;
                end else if (timer == TMAX) begin
                    resp_n[ptr].err = ERR;
                    resp_n[ptr].tid = req_o.tid;
                    state_n         = RESP;
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            RESP: begin
                grant_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; resp_o defaults to zero so each response lasts one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= IW'(NREQ - 1);
            grant_o <= '0;
            req_o   <= '0;
            timer   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                resp_o[i] <= '0;
            end
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            grant_o <= grant_n;
            req_o   <= req_n;
            timer   <= timer_n;
            for (int i = 0; i < NREQ; i++) begin
                resp_o[i] <= resp_n[i];
            end
        end
    end

endmodule
